// File: rtl/dfdd_pkg.sv
// Shared DFDD pyramid types: pixel tags, alignment FSM states and FP16 widths.
package dfdd_pkg;

    localparam int unsigned FP16_WIDTH     = 16;
    localparam int unsigned FP16_EXP_WIDTH = 5;
    localparam int unsigned FP16_MAN_WIDTH = 10;
    localparam int unsigned TAG_WIDTH      = 32;

    typedef struct packed {
        logic [15:0] col;
        logic [15:0] row;
    } pixel_tag_t;

    typedef enum logic {
        ALIGN_RUN    = 1'b0,
        ALIGN_RESYNC = 1'b1
    } align_state_e;

endpackage

// File: rtl/fwft_fifo.sv
// Show-ahead FIFO: RAM body plus a one-entry head register that always holds the oldest entry.
module fwft_fifo #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [LEVEL_WIDTH-1:0] level_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [WIDTH-1:0]       head_q;
    logic                   head_valid_q, head_valid_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   push_ok, pop_ok, refill, ram_nonempty;
    logic                   load_ram, load_bypass, ram_we;

    assign full_o       = (level_q == LEVEL_WIDTH'(DEPTH));
    assign empty_o      = !head_valid_q;
    assign ram_nonempty = (level_q > LEVEL_WIDTH'(head_valid_q));
    assign dout_o       = head_q;
    assign level_o      = level_q;

    // The head is refilled from RAM when RAM holds data, otherwise straight from the input,
    // so the RAM never reads and writes the same slot in one cycle.
    always_comb begin
        pop_ok       = pop_i && head_valid_q;
        push_ok      = push_i && (!full_o || pop_ok);
        refill       = pop_ok || !head_valid_q;
        load_ram     = refill && ram_nonempty;
        load_bypass  = refill && !ram_nonempty && push_ok;
        ram_we       = push_ok && !load_bypass;
        head_valid_d = head_valid_q;
        if (refill) begin
            head_valid_d = load_ram || load_bypass;
        end
        rd_ptr_d = rd_ptr_q + AW'(load_ram);
        wr_ptr_d = wr_ptr_q + AW'(ram_we);
        level_d  = level_q + LEVEL_WIDTH'(push_ok) - LEVEL_WIDTH'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem[wr_ptr_q] <= din_i;
        end
        if (load_ram) begin
            head_q <= mem[rd_ptr_q];
        end else if (load_bypass) begin
            head_q <= din_i;
        end
    end

endmodule

// File: rtl/pyramid_stream_aligner.sv
// Buffers raw pixels until the processed pixel with the same tag arrives, then emits both aligned.
module pyramid_stream_aligner
    import dfdd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = FP16_WIDTH,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  raw_data_i,
    input  logic [15:0]                          raw_col_i,
    input  logic [15:0]                          raw_row_i,
    input  logic                                 raw_valid_i,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  proc_data_i,
    input  logic [15:0]                          proc_col_i,
    input  logic [15:0]                          proc_row_i,
    input  logic                                 proc_valid_i,
    output logic [CHANNELS-1:0][DATA_WIDTH-1:0]  raw_data_o,
    output logic [CHANNELS-1:0][DATA_WIDTH-1:0]  proc_data_o,
    output logic [15:0]                          col_o,
    output logic [15:0]                          row_o,
    output logic                                 valid_o,
    output logic                                 overflow_o,
    output logic                                 underflow_o,
    output logic                                 mismatch_o,
    output logic [LEVEL_WIDTH-1:0]               level_o
);

    localparam int unsigned DW = DATA_WIDTH * CHANNELS;
    localparam int unsigned EW = DW + TAG_WIDTH;

    typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] lanes_t;

    align_state_e state_q, state_d;
    lanes_t       raw_data_q, raw_data_d, proc_data_q, proc_data_d, head_data;
    pixel_tag_t   tag_q, tag_d, head_tag, raw_tag, proc_tag;
    logic         valid_q, valid_d;
    logic         overflow_q, overflow_d, underflow_q, underflow_d, mismatch_q, mismatch_d;
    logic         pop, emit, fifo_full, fifo_empty;
    logic [EW-1:0] fifo_dout;

    assign raw_tag  = '{col: raw_col_i, row: raw_row_i};
    assign proc_tag = '{col: proc_col_i, row: proc_row_i};
    assign {head_data, head_tag} = fifo_dout;

    fwft_fifo #(
        .WIDTH       (EW),
        .DEPTH       (DEPTH),
        .LEVEL_WIDTH (LEVEL_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (raw_valid_i),
        .din_i   ({raw_data_i, raw_tag}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        emit        = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mismatch_d  = mismatch_q;
        case (state_q)
            ALIGN_RUN: begin
                if (proc_valid_i) begin
                    if (fifo_empty) begin
                        underflow_d = 1'b1;
                    end else if (head_tag == proc_tag) begin
                        pop  = 1'b1;
                        emit = 1'b1;
                    end else begin
                        mismatch_d = 1'b1;
                        pop        = 1'b1;
                        state_d    = ALIGN_RESYNC;
                    end
                end
            end
            ALIGN_RESYNC: begin
                // Flush stale entries until a frame start (0,0) heads the FIFO.
                if (!fifo_empty) begin
                    if (head_tag != '0) begin
                        pop = 1'b1;
                    end else if (proc_valid_i && proc_tag == '0) begin
                        pop     = 1'b1;
                        emit    = 1'b1;
                        state_d = ALIGN_RUN;
                    end
                end
            end
        endcase
        if (raw_valid_i && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        valid_d     = emit;
        raw_data_d  = emit ? head_data : raw_data_q;
        proc_data_d = emit ? proc_data_i : proc_data_q;
        tag_d       = emit ? proc_tag : tag_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ALIGN_RUN;
            valid_q     <= 1'b0;
            raw_data_q  <= '0;
            proc_data_q <= '0;
            tag_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            raw_data_q  <= raw_data_d;
            proc_data_q <= proc_data_d;
            tag_q       <= tag_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign raw_data_o  = raw_data_q;
    assign proc_data_o = proc_data_q;
    assign col_o       = tag_q.col;
    assign row_o       = tag_q.row;
    assign valid_o     = valid_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign mismatch_o  = mismatch_q;

endmodule

// File: tb/tb_pyramid_stream_aligner.sv
// Directed bench: three aligner instances (DEPTH 16/8/4) share stimulus; each test checks one.
module tb_pyramid_stream_aligner;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][15:0] raw_data, proc_data;
    logic [15:0]      raw_col, raw_row, proc_col, proc_row;
    logic             raw_valid, proc_valid;

    logic [1:0][15:0] raw_data_o  [3];
    logic [1:0][15:0] proc_data_o [3];
    logic [15:0]      col_o [3];
    logic [15:0]      row_o [3];
    logic             valid_o [3];
    logic             overflow_o [3];
    logic             underflow_o [3];
    logic             mismatch_o [3];
    logic [4:0]       level_o [3];

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;
    int ri, pi;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 16 : (g == 1) ? 8 : 4;
        pyramid_stream_aligner #(
            .DATA_WIDTH  (16),
            .CHANNELS    (2),
            .DEPTH       (D),
            .LEVEL_WIDTH (5)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .raw_data_i   (raw_data),
            .raw_col_i    (raw_col),
            .raw_row_i    (raw_row),
            .raw_valid_i  (raw_valid),
            .proc_data_i  (proc_data),
            .proc_col_i   (proc_col),
            .proc_row_i   (proc_row),
            .proc_valid_i (proc_valid),
            .raw_data_o   (raw_data_o[g]),
            .proc_data_o  (proc_data_o[g]),
            .col_o        (col_o[g]),
            .row_o        (row_o[g]),
            .valid_o      (valid_o[g]),
            .overflow_o   (overflow_o[g]),
            .underflow_o  (underflow_o[g]),
            .mismatch_o   (mismatch_o[g]),
            .level_o      (level_o[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic v, input int c, input int r, input logic [31:0] d);
        raw_valid = v;
        raw_col   = 16'(c);
        raw_row   = 16'(r);
        raw_data  = d;
    endtask

    task automatic set_proc(input logic v, input int c, input int r, input logic [31:0] d);
        proc_valid = v;
        proc_col   = 16'(c);
        proc_row   = 16'(r);
        proc_data  = d;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        set_raw(1'b0, 0, 0, 32'h0);
        set_proc(1'b0, 0, 0, 32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_flags(input string tag, input int g, input logic ov, input logic un, input logic mm);
        check({tag, "_ovf"}, 64'(overflow_o[g]), 64'(ov));
        check({tag, "_unf"}, 64'(underflow_o[g]), 64'(un));
        check({tag, "_mis"}, 64'(mismatch_o[g]), 64'(mm));
    endtask

    initial begin
        reset_all();
        check("rst_valid", 64'(valid_o[0]), 64'd0);
        check("rst_level", 64'(level_o[0]), 64'd0);
        check("rst_col", 64'(col_o[0]), 64'd0);
        check("rst_data", 64'(raw_data_o[0]), 64'd0);
        check_flags("rst", 0, 1'b0, 1'b0, 1'b0);

        // Steady state: 4x4 frame, processed stream lags raw by 10 cycles.
        reset_all();
        pulses = 0;
        for (int c = 0; c < 26; c++) begin
            ri = c;
            pi = c - 10;
            set_raw(c < 16, ri % 4, ri / 4, {16'h2000 + 16'(ri), 16'h1000 + 16'(ri)});
            set_proc(pi >= 0 && pi < 16, pi % 4, pi / 4, {16'h4000 + 16'(pi), 16'h3000 + 16'(pi)});
            step();
            if (valid_o[0]) pulses++;
            if (proc_valid) begin
                check("ss_valid", 64'(valid_o[0]), 64'd1);
                check("ss_col", 64'(col_o[0]), 64'(pi % 4));
                check("ss_row", 64'(row_o[0]), 64'(pi / 4));
                check("ss_raw", 64'(raw_data_o[0]), 64'({16'h2000 + 16'(pi), 16'h1000 + 16'(pi)}));
                check("ss_proc", 64'(proc_data_o[0]), 64'({16'h4000 + 16'(pi), 16'h3000 + 16'(pi)}));
            end else begin
                check("ss_idle", 64'(valid_o[0]), 64'd0);
            end
        end
        check("ss_pulses", 64'(pulses), 64'd16);
        check("ss_level", 64'(level_o[0]), 64'd0);
        check_flags("ss", 0, 1'b0, 1'b0, 1'b0);

        // Overflow on the DEPTH=8 instance.
        reset_all();
        for (int i = 0; i < 9; i++) begin
            set_raw(1'b1, i, 1, {16'h6000 + 16'(i), 16'h5000 + 16'(i)});
            step();
            if (i == 7) begin
                check("ovf_pre_flag", 64'(overflow_o[1]), 64'd0);
                check("ovf_pre_level", 64'(level_o[1]), 64'd8);
            end
        end
        check("ovf_flag", 64'(overflow_o[1]), 64'd1);
        check("ovf_level", 64'(level_o[1]), 64'd8);
        set_raw(1'b0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            set_proc(1'b1, i, 1, 32'hABCD_0000 + 32'(i));
            step();
            check("ovf_drain_valid", 64'(valid_o[1]), 64'd1);
            check("ovf_drain_col", 64'(col_o[1]), 64'(i));
            check("ovf_drain_raw", 64'(raw_data_o[1]), 64'({16'h6000 + 16'(i), 16'h5000 + 16'(i)}));
        end
        set_proc(1'b1, 8, 1, 32'h0);
        step();
        check("ovf_ninth_gone", 64'(valid_o[1]), 64'd0);
        check("ovf_ninth_unf", 64'(underflow_o[1]), 64'd1);
        check("ovf_ninth_level", 64'(level_o[1]), 64'd0);

        // Same-cycle push and processed pixel with an empty FIFO.
        reset_all();
        set_raw(1'b1, 0, 0, 32'hA001_A000);
        set_proc(1'b1, 0, 0, 32'hB001_B000);
        step();
        check("unf_flag", 64'(underflow_o[0]), 64'd1);
        check("unf_valid", 64'(valid_o[0]), 64'd0);
        check("unf_level", 64'(level_o[0]), 64'd1);
        set_raw(1'b0, 0, 0, 32'h0);
        step();
        check("unf_next_valid", 64'(valid_o[0]), 64'd1);
        check("unf_next_raw", 64'(raw_data_o[0]), 64'h0000_0000_A001_A000);
        check("unf_sticky", 64'(underflow_o[0]), 64'd1);

        // Mismatch then resync on the next frame start.
        reset_all();
        for (int i = 0; i < 3; i++) begin
            set_raw(1'b1, i, 0, 32'h0C00_0000 + 32'(i));
            step();
        end
        set_raw(1'b0, 0, 0, 32'h0);
        set_proc(1'b1, 1, 0, 32'h0);
        step();
        check("mis_flag", 64'(mismatch_o[0]), 64'd1);
        check("mis_valid", 64'(valid_o[0]), 64'd0);
        check("mis_level", 64'(level_o[0]), 64'd2);
        set_proc(1'b1, 0, 0, 32'h0);
        step();
        check("mis_drop_valid", 64'(valid_o[0]), 64'd0);
        check("mis_drop_level", 64'(level_o[0]), 64'd1);
        set_proc(1'b0, 0, 0, 32'h0);
        step();
        check("mis_flushed", 64'(level_o[0]), 64'd0);
        set_raw(1'b1, 0, 0, 32'h7001_7000);
        step();
        set_raw(1'b0, 0, 0, 32'h0);
        set_proc(1'b1, 0, 0, 32'h8001_8000);
        step();
        check("resync_valid", 64'(valid_o[0]), 64'd1);
        check("resync_tag", 64'({col_o[0], row_o[0]}), 64'd0);
        check("resync_raw", 64'(raw_data_o[0]), 64'h0000_0000_7001_7000);
        check("resync_proc", 64'(proc_data_o[0]), 64'h0000_0000_8001_8000);
        set_proc(1'b0, 0, 0, 32'h0);
        step();
        check("resync_single", 64'(valid_o[0]), 64'd0);
        check_flags("resync", 0, 1'b0, 1'b0, 1'b1);

        // Full DEPTH=4: push and match together, then reset mid-frame.
        reset_all();
        for (int i = 0; i < 4; i++) begin
            set_raw(1'b1, i, 2, 32'hD000_0000 + 32'(i));
            step();
        end
        check("full_level", 64'(level_o[2]), 64'd4);
        set_raw(1'b1, 4, 2, 32'hD000_0004);
        set_proc(1'b1, 0, 2, 32'hE000_0000);
        step();
        check("full_pp_valid", 64'(valid_o[2]), 64'd1);
        check("full_pp_tag", 64'({col_o[2], row_o[2]}), 64'h0000_0002);
        check("full_pp_level", 64'(level_o[2]), 64'd4);
        check("full_pp_ovf", 64'(overflow_o[2]), 64'd0);
        set_raw(1'b1, 5, 2, 32'hD000_0005);
        set_proc(1'b1, 1, 2, 32'hE000_0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_raw(1'b0, 0, 0, 32'h0);
        set_proc(1'b0, 0, 0, 32'h0);
        check("mid_rst_valid", 64'(valid_o[2]), 64'd0);
        check("mid_rst_level", 64'(level_o[2]), 64'd0);
        check("mid_rst_tag", 64'({col_o[2], row_o[2]}), 64'd0);
        check("mid_rst_data", 64'({raw_data_o[2], proc_data_o[2]}), 64'd0);
        check_flags("mid_rst", 2, 1'b0, 1'b0, 1'b0);
        set_raw(1'b1, 9, 9, 32'h0909_0909);
        step();
        set_raw(1'b0, 0, 0, 32'h0);
        set_proc(1'b1, 9, 9, 32'h0);
        step();
        check("post_rst_run_valid", 64'(valid_o[2]), 64'd1);
        check("post_rst_run_col", 64'(col_o[2]), 64'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
